// File: rtl/basys_clkgen_if.sv
// Board-side signal bundle for the clock/step front end.
// master: the board/bench side driving the raw controls.
// slave:  the clock generator itself.
interface basys_clkgen_if;
    logic       btn_step;
    logic       sw_run;
    logic       internal_clk;
    logic       real_clk;
    logic [7:0] step_count;

    modport master (
        output btn_step, sw_run,
        input  internal_clk, real_clk, step_count
    );

    modport slave (
        input  btn_step, sw_run,
        output internal_clk, real_clk, step_count
    );
endinterface

// File: rtl/basys_clkgen.sv
// Clock and step-control front end for the Basys build.
// internal_clk: divided display-refresh square wave.
// real_clk:     one debounced pulse per step press, or a free-running
//               divided clock in run mode, with glitch-free mode changes.
// step_count:   number of real_clk rising edges, modulo 256.
module basys_clkgen #(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 4,
    parameter int RUN_DIV         = 5000000
) (
    input  logic          clk,
    input  logic          reset,
    basys_clkgen_if.slave bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int UW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES);
    localparam logic [UW-1:0] RUN_LAST   = UW'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PULSE,
        HELD,
        DEB_REL
    } state_t;

    logic          btn_meta, btn_s;
    logic          run_meta, run_s;

    logic [RW-1:0] ref_cnt;
    logic          int_clk_r;

    state_t        state, state_n;
    logic [DW-1:0] deb_cnt, deb_n;
    logic [PW-1:0] pulse_cnt, pulse_n;
    logic [UW-1:0] run_cnt, run_cnt_n;
    logic          run_mode, run_mode_n;
    logic          real_clk_r, real_n;
    logic [7:0]    step_cnt_r;
    logic          mode_ok;

    // Two-flop synchronizers for the raw button and mode switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            run_meta <= 1'b0;
            run_s    <= 1'b0;
        end else begin
            btn_meta <= bus.btn_step;
            btn_s    <= btn_meta;
            run_meta <= bus.sw_run;
            run_s    <= run_meta;
        end
    end

    // Refresh divider: internal_clk toggles every REFRESH_DIV cycles, any mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt   <= '0;
            int_clk_r <= 1'b0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            int_clk_r <= ~int_clk_r;
        end else begin
            ref_cnt   <= ref_cnt + RW'(1);
        end
    end

    // Step FSM, run divider and mode register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            pulse_cnt  <= '0;
            run_cnt    <= '0;
            run_mode   <= 1'b0;
            real_clk_r <= 1'b0;
        end else begin
            state      <= state_n;
            deb_cnt    <= deb_n;
            pulse_cnt  <= pulse_n;
            run_cnt    <= run_cnt_n;
            run_mode   <= run_mode_n;
            real_clk_r <= real_n;
        end
    end

    // Mode change only while real_clk is low and no press/pulse is in flight,
    // so neither a step pulse nor a run high phase is ever truncated.
    assign mode_ok = !real_clk_r && (state == IDLE || state == HELD);

    // Next-state logic: mode switch first, then run divider or step FSM.
    always_comb begin
        state_n    = state;
        deb_n      = deb_cnt;
        pulse_n    = pulse_cnt;
        run_cnt_n  = run_cnt;
        run_mode_n = run_mode;
        real_n     = real_clk_r;

        if (mode_ok && (run_s != run_mode)) begin
            run_mode_n = run_s;
            run_cnt_n  = '0;
            deb_n      = '0;
            // A button still held when leaving run mode must be released
            // before it can step, hence HELD rather than IDLE.
            state_n    = (!run_s && btn_s) ? HELD : IDLE;
        end else if (run_mode) begin
            state_n = IDLE;
            if (run_cnt == RUN_LAST) begin
                run_cnt_n = '0;
                real_n    = ~real_clk_r;
            end else begin
                run_cnt_n = run_cnt + UW'(1);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state_n = DEB_PRESS;
                        deb_n   = DW'(1);
                    end
                end
                DEB_PRESS: begin
                    if (!btn_s) begin
                        state_n = IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_n = PULSE;
                        real_n  = 1'b1;
                        pulse_n = PW'(1);
                    end else begin
                        deb_n   = deb_cnt + DW'(1);
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_n = HELD;
                        real_n  = 1'b0;
                    end else begin
                        pulse_n = pulse_cnt + PW'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_n = DEB_REL;
                        deb_n   = DW'(1);
                    end
                end
                DEB_REL: begin
                    if (btn_s) begin
                        state_n = HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_n = IDLE;
                    end else begin
                        deb_n   = deb_cnt + DW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Count real_clk rising edges on the same edge the rise is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_r <= 8'd0;
        end else if (real_n && !real_clk_r) begin
            step_cnt_r <= step_cnt_r + 8'd1;
        end
    end

    assign bus.internal_clk = int_clk_r;
    assign bus.real_clk     = real_clk_r;
    assign bus.step_count   = step_cnt_r;
endmodule
